// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - load/store unit mode constants, FSM states and lane helpers
package lsu_pkg;

   localparam logic [2:0] LS_B  = 3'b000;
   localparam logic [2:0] LS_H  = 3'b001;
   localparam logic [2:0] LS_W  = 3'b010;
   localparam logic [2:0] LS_BU = 3'b100;
   localparam logic [2:0] LS_HU = 3'b101;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      RESP = 2'd2
   } lsu_state_t;

   // Byte enables of a store of the given width at byte offset off.
   function automatic logic [3:0] be_for(input logic [2:0] mode, input logic [1:0] off);
      case (mode)
         LS_B, LS_BU: be_for = 4'b0001 << off;
         LS_H, LS_HU: be_for = off[1] ? 4'b1100 : 4'b0011;
         default:     be_for = 4'b1111;
      endcase
   endfunction

   // Offset actually used for lane selection: halves drop bit 0, words drop both bits.
   function automatic logic [1:0] align_off(input logic [2:0] mode, input logic [1:0] off);
      case (mode)
         LS_B, LS_BU: align_off = off;
         LS_H, LS_HU: align_off = {off[1], 1'b0};
         default:     align_off = 2'b00;
      endcase
   endfunction

   function automatic logic is_misaligned(input logic [2:0] mode, input logic [1:0] off);
      case (mode)
         LS_H, LS_HU: is_misaligned = off[0];
         LS_W:        is_misaligned = (off != 2'b00);
         default:     is_misaligned = 1'b0;
      endcase
   endfunction

   // Store data replicated across every lane the access could target.
   function automatic logic [31:0] wdata_rep(input logic [2:0] mode, input logic [31:0] data);
      case (mode)
         LS_B:    wdata_rep = {4{data[7:0]}};
         LS_H:    wdata_rep = {2{data[15:0]}};
         default: wdata_rep = data;
      endcase
   endfunction

endpackage

// File: rtl/lsu_load_align.sv
// rtl/lsu_load_align.sv - selects and sign/zero-extends the loaded byte/half/word
module lsu_load_align
   import lsu_pkg::*;
(
   input  logic [2:0]  i_mode,
   input  logic [1:0]  i_off,
   input  logic [31:0] i_word,
   output logic [31:0] o_result
);

   logic [7:0]  w_byte;
   logic [15:0] w_half;

   // Pick the addressed byte and half out of the memory word.
   always_comb begin
      w_byte = i_word[7:0];
      case (i_off)
         2'd0: w_byte = i_word[7:0];
         2'd1: w_byte = i_word[15:8];
         2'd2: w_byte = i_word[23:16];
         2'd3: w_byte = i_word[31:24];
         default: w_byte = i_word[7:0];
      endcase
      w_half = i_off[1] ? i_word[31:16] : i_word[15:0];
   end

   // Extend according to the signed/unsigned width in the mode.
   always_comb begin
      o_result = i_word;
      case (i_mode)
         LS_B:    o_result = {{24{w_byte[7]}}, w_byte};
         LS_BU:   o_result = {24'h0, w_byte};
         LS_H:    o_result = {{16{w_half[15]}}, w_half};
         LS_HU:   o_result = {16'h0, w_half};
         default: o_result = i_word;
      endcase
   end

endmodule

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - req/ack data-memory load/store unit (option: LSU_MISALIGN_TRAP_EN)
module load_store_unit
   import lsu_pkg::*;
#(
   parameter int AW = 32
)(
   input  logic          i_clk,
   input  logic          i_rst,
   input  logic          i_start,
   input  logic          i_MemRw,
   input  logic [2:0]    i_LoadStoreMode,
   input  logic [AW-1:0] i_addr,
   input  logic [31:0]   i_wdata,
   output logic          o_busy,
   output logic          o_done,
   output logic          o_err,
   output logic [31:0]   o_rdata,
   output logic          o_mem_req,
   output logic          o_mem_we,
   output logic [AW-1:0] o_mem_addr,
   output logic [3:0]    o_mem_be,
   output logic [31:0]   o_mem_wdata,
   input  logic          i_mem_ack,
   input  logic [31:0]   i_mem_rdata
);

   lsu_state_t    r_state;
   logic          r_rw;
   logic [2:0]    r_mode;
   logic [1:0]    r_off;
   logic          r_busy;
   logic          r_done;
   logic          r_err;
   logic [31:0]   r_rdata;
   logic          r_mem_req;
   logic          r_mem_we;
   logic [AW-1:0] r_mem_addr;
   logic [3:0]    r_mem_be;
   logic [31:0]   r_mem_wdata;

   logic [1:0]    w_off;
   logic          w_mode_ok;
   logic          w_legal;
   logic [31:0]   w_load_result;

   // Classify the incoming request: legal mode for its direction, and alignment policy.
   always_comb begin
      w_off = align_off(i_LoadStoreMode, i_addr[1:0]);
      if (i_MemRw)
         w_mode_ok = (i_LoadStoreMode == LS_B) || (i_LoadStoreMode == LS_H) ||
                     (i_LoadStoreMode == LS_W);
      else
         w_mode_ok = (i_LoadStoreMode != 3'b011) && (i_LoadStoreMode != 3'b110) &&
                     (i_LoadStoreMode != 3'b111);
`ifdef LSU_MISALIGN_TRAP_EN
      w_legal = w_mode_ok && !is_misaligned(i_LoadStoreMode, i_addr[1:0]);
`else
      w_legal = w_mode_ok;
`endif
   end

   lsu_load_align u_load_align (
      .i_mode   (r_mode),
      .i_off    (r_off),
      .i_word   (i_mem_rdata),
      .o_result (w_load_result)
   );

   // IDLE -> REQ (or straight to RESP on a rejected access) -> RESP -> IDLE.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state     <= IDLE;
         r_rw        <= 1'b0;
         r_mode      <= 3'b000;
         r_off       <= 2'b00;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
         r_err       <= 1'b0;
         r_rdata     <= 32'h0;
         r_mem_req   <= 1'b0;
         r_mem_we    <= 1'b0;
         r_mem_addr  <= '0;
         r_mem_be    <= 4'b0000;
         r_mem_wdata <= 32'h0;
      end else begin
         r_done <= 1'b0;
         r_err  <= 1'b0;
         case (r_state)
            IDLE: begin
               if (i_start) begin
                  r_busy <= 1'b1;
                  r_rw   <= i_MemRw;
                  r_mode <= i_LoadStoreMode;
                  r_off  <= w_off;
                  if (w_legal) begin
                     r_mem_req   <= 1'b1;
                     r_mem_we    <= i_MemRw;
                     r_mem_addr  <= {i_addr[AW-1:2], 2'b00};
                     r_mem_be    <= i_MemRw ? be_for(i_LoadStoreMode, w_off) : 4'b1111;
                     r_mem_wdata <= i_MemRw ? wdata_rep(i_LoadStoreMode, i_wdata) : 32'h0;
                     r_state     <= REQ;
                  end else begin
                     r_done  <= 1'b1;
                     r_err   <= 1'b1;
                     r_state <= RESP;
                  end
               end
            end
            REQ: begin
               if (i_mem_ack) begin
                  r_mem_req <= 1'b0;
                  r_mem_we  <= 1'b0;
                  if (!r_rw)
                     r_rdata <= w_load_result;
                  r_done    <= 1'b1;
                  r_state   <= RESP;
               end
            end
            RESP: begin
               r_busy  <= 1'b0;
               r_state <= IDLE;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign o_busy      = r_busy;
   assign o_done      = r_done;
   assign o_err       = r_err;
   assign o_rdata     = r_rdata;
   assign o_mem_req   = r_mem_req;
   assign o_mem_we    = r_mem_we;
   assign o_mem_addr  = r_mem_addr;
   assign o_mem_be    = r_mem_be;
   assign o_mem_wdata = r_mem_wdata;

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - scoreboard bench for load_store_unit
module tb_load_store_unit;
   import lsu_pkg::*;

   logic        clk = 1'b0;
   logic        i_rst = 1'b1;
   logic        i_start = 1'b0;
   logic        i_MemRw = 1'b0;
   logic [2:0]  i_LoadStoreMode = 3'b000;
   logic [31:0] i_addr = 32'h0;
   logic [31:0] i_wdata = 32'h0;
   logic        i_mem_ack = 1'b0;
   logic [31:0] i_mem_rdata = 32'h0;
   logic        o_busy, o_done, o_err, o_mem_req, o_mem_we;
   logic [31:0] o_rdata, o_mem_addr, o_mem_wdata;
   logic [3:0]  o_mem_be;

   always #5 clk = ~clk;

   load_store_unit #(.AW(32)) dut (
      .i_clk(clk), .i_rst(i_rst), .i_start(i_start), .i_MemRw(i_MemRw),
      .i_LoadStoreMode(i_LoadStoreMode), .i_addr(i_addr), .i_wdata(i_wdata),
      .o_busy(o_busy), .o_done(o_done), .o_err(o_err), .o_rdata(o_rdata),
      .o_mem_req(o_mem_req), .o_mem_we(o_mem_we), .o_mem_addr(o_mem_addr),
      .o_mem_be(o_mem_be), .o_mem_wdata(o_mem_wdata),
      .i_mem_ack(i_mem_ack), .i_mem_rdata(i_mem_rdata)
   );

   typedef struct {
      int          tag;
      logic        err;
      logic        chk_rdata;
      logic [31:0] rdata;
      int          start_cyc;
      int          lat;
   } exp_t;

   exp_t sb_q[$];
   int   cyc = 0;
   int   n_checks = 0;
   int   n_fail = 0;
   logic saw_req = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input int tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s (vector %0d): got 0x%08h expected 0x%08h", name, tag, act, exp);
      end
   endtask

   // Monitor: pops the scoreboard on every done pulse.
   always @(negedge clk) begin
      exp_t e;
      if (o_mem_req) saw_req = 1'b1;
      if (o_done) begin
         if (sb_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_done at cycle %0d: got done=1 expected none", cyc);
         end else begin
            e = sb_q.pop_front();
            chk("done_err", e.tag, {31'h0, o_err}, {31'h0, e.err});
            chk("done_latency", e.tag, cyc - e.start_cyc, e.lat);
            if (e.chk_rdata) chk("rdata", e.tag, o_rdata, e.rdata);
         end
      end
   end

   task automatic do_access(input int tag, input logic rw, input logic [2:0] mode,
                            input logic [31:0] addr, input logic [31:0] wdata,
                            input logic [31:0] mrd, input int waits, input logic exp_err,
                            input logic [31:0] exp_rd, input logic [31:0] exp_addr,
                            input logic [3:0] exp_be, input logic [31:0] exp_wdata,
                            input logic dbl_start);
      exp_t e;
      e.tag = tag;
      e.err = exp_err;
      e.chk_rdata = !exp_err && !rw;
      e.rdata = exp_rd;
      e.start_cyc = cyc;
      e.lat = exp_err ? 1 : 2 + waits;
      sb_q.push_back(e);
      saw_req = 1'b0;
      i_start = 1'b1; i_MemRw = rw; i_LoadStoreMode = mode; i_addr = addr; i_wdata = wdata;
      @(negedge clk);
      if (dbl_start) begin
         i_MemRw = 1'b0; i_LoadStoreMode = LS_W; i_addr = 32'hA000;
      end else begin
         i_start = 1'b0;
      end
      chk("busy_cycle1", tag, {31'h0, o_busy}, 32'h1);
      if (exp_err) begin
         chk("no_req_cycle1", tag, {31'h0, o_mem_req}, 32'h0);
         @(negedge clk);
         i_start = 1'b0;
         chk("busy_fall", tag, {31'h0, o_busy}, 32'h0);
         chk("no_mem_traffic", tag, {31'h0, saw_req}, 32'h0);
      end else begin
         for (int w = 0; w <= waits; w++) begin
            chk("mem_req", tag, {31'h0, o_mem_req}, 32'h1);
            chk("mem_we", tag, {31'h0, o_mem_we}, {31'h0, rw});
            chk("mem_addr", tag, o_mem_addr, exp_addr);
            chk("mem_be", tag, {28'h0, o_mem_be}, {28'h0, exp_be});
            if (rw) chk("mem_wdata", tag, o_mem_wdata, exp_wdata);
            if (w == waits) begin
               i_mem_ack = 1'b1; i_mem_rdata = mrd;
            end
            @(negedge clk);
            i_mem_ack = 1'b0; i_mem_rdata = 32'h0;
         end
         chk("busy_done_cycle", tag, {31'h0, o_busy}, 32'h1);
         chk("req_dropped", tag, {31'h0, o_mem_req}, 32'h0);
         @(negedge clk);
         chk("busy_fall", tag, {31'h0, o_busy}, 32'h0);
      end
      @(negedge clk);
   endtask

   task automatic chk_all_zero(input int tag);
      chk("rst_busy", tag, {31'h0, o_busy}, 32'h0);
      chk("rst_done", tag, {31'h0, o_done}, 32'h0);
      chk("rst_err", tag, {31'h0, o_err}, 32'h0);
      chk("rst_rdata", tag, o_rdata, 32'h0);
      chk("rst_mem_req", tag, {31'h0, o_mem_req}, 32'h0);
      chk("rst_mem_we", tag, {31'h0, o_mem_we}, 32'h0);
      chk("rst_mem_addr", tag, o_mem_addr, 32'h0);
      chk("rst_mem_be", tag, {28'h0, o_mem_be}, 32'h0);
      chk("rst_mem_wdata", tag, o_mem_wdata, 32'h0);
   endtask

   initial begin
      repeat (2) @(negedge clk);
      chk_all_zero(0);
      i_rst = 1'b0;
      @(negedge clk);

      //        tag rw   mode   addr        wdata         mrd          w  err   exp_rd        exp_addr    be       exp_wdata     dbl
      do_access(1, 1'b0, LS_B,  32'h1003, 32'h0,        32'h80FF1234, 0, 1'b0, 32'hFFFFFF80, 32'h1000, 4'b1111, 32'h0,        1'b0);
      do_access(2, 1'b0, LS_HU, 32'h2002, 32'h0,        32'hBEEF0001, 3, 1'b0, 32'h0000BEEF, 32'h2000, 4'b1111, 32'h0,        1'b0);
      do_access(3, 1'b1, LS_B,  32'h3001, 32'h000000A5, 32'h0,        0, 1'b0, 32'h0,        32'h3000, 4'b0010, 32'hA5A5A5A5, 1'b0);
`ifdef LSU_MISALIGN_TRAP_EN
      do_access(4, 1'b1, LS_W,  32'h4002, 32'h11223344, 32'h0,        0, 1'b1, 32'h0,        32'h0,    4'b0000, 32'h0,        1'b0);
`else
      do_access(4, 1'b1, LS_W,  32'h4002, 32'h11223344, 32'h0,        0, 1'b0, 32'h0,        32'h4000, 4'b1111, 32'h11223344, 1'b0);
`endif
      do_access(5, 1'b0, LS_H,  32'h5000, 32'h0,        32'h12348001, 0, 1'b0, 32'hFFFF8001, 32'h5000, 4'b1111, 32'h0,        1'b0);
      do_access(6, 1'b0, LS_BU, 32'h6002, 32'h0,        32'h00C30000, 1, 1'b0, 32'h000000C3, 32'h6000, 4'b1111, 32'h0,        1'b0);
      do_access(7, 1'b1, LS_H,  32'h7002, 32'h1234BEEF, 32'h0,        0, 1'b0, 32'h0,        32'h7000, 4'b1100, 32'hBEEFBEEF, 1'b0);
      do_access(8, 1'b0, LS_W,  32'h8004, 32'h0,        32'hDEADBEEF, 2, 1'b0, 32'hDEADBEEF, 32'h8004, 4'b1111, 32'h0,        1'b0);
      do_access(9, 1'b1, 3'b100, 32'h9000, 32'h5555AAAA, 32'h0,       0, 1'b1, 32'h0,        32'h0,    4'b0000, 32'h0,        1'b0);
      do_access(10, 1'b0, 3'b111, 32'h9004, 32'h0,      32'h0,        0, 1'b1, 32'h0,        32'h0,    4'b0000, 32'h0,        1'b1);
      chk("rdata_held_after_err", 10, o_rdata, 32'hDEADBEEF);

      // Reset while REQ is pending, then a late ack that must be ignored.
      i_start = 1'b1; i_MemRw = 1'b0; i_LoadStoreMode = LS_W; i_addr = 32'hB000;
      @(negedge clk);
      i_start = 1'b0;
      chk("req_before_rst", 11, {31'h0, o_mem_req}, 32'h1);
      i_rst = 1'b1;
      @(negedge clk);
      chk_all_zero(11);
      i_rst = 1'b0;
      i_mem_ack = 1'b1; i_mem_rdata = 32'hFFFFFFFF;
      @(negedge clk);
      i_mem_ack = 1'b0; i_mem_rdata = 32'h0;
      chk_all_zero(12);
      repeat (3) @(negedge clk);
      chk("no_done_after_rst", 12, {31'h0, o_done}, 32'h0);

      chk("scoreboard_empty", 13, sb_q.size(), 32'h0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Data-memory side of the core's load/store path. Accepts one access per request, using the 3-bit `LoadStoreMode` (funct3) and `MemRw` encoding produced by the instruction decoder. Runs a req/ack transaction on a 32-bit word-addressed data memory, with byte-lane enables, write-data replication and load sign/zero extension. Sits between the execute stage (address = ALU result, write data = rs2) and the data memory; its `rdata` feeds writeback select 00.

## Interface
- `AW`, 32, byte-address width.
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst`  in  1  reset. Synchronous, active-high.
- `start`  in  1  request strobe; accepted only when `busy`=0.
- `MemRw`  in  1  1 = store, 0 = load.
- `LoadStoreMode`  in  3  funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- `addr`  in  AW  byte address.
- `wdata`  in  32  store data (rs2).
- `busy`  out  1  access in flight.
- `done`  out  1  one-cycle completion pulse.
- `err`  out  1  one-cycle pulse coincident with `done` on a rejected access.
- `rdata`  out  32  extended load result; valid while `done`=1, held until the next `done`.
- `mem_req`  out  1  memory request, held until ack.
- `mem_we`  out  1  write enable.
- `mem_addr`  out  AW  word address, {addr[AW-1:2],2'b00}.
- `mem_be`  out  4  byte enables.
- `mem_wdata`  out  32  lane-replicated store data.
- `mem_ack`  in  1  memory accept/complete, single cycle.
- `mem_rdata`  in  32  read word, valid with `mem_ack`.

## Operation
- FSM states: IDLE, REQ, RESP.
- IDLE + `start`:
  - Latch `MemRw`, mode, `addr`, `wdata`; set `busy`.
  - Legal access → REQ.
  - Illegal access → RESP with `err`=1 and no memory traffic.
- Illegal access: stores with mode ≠ 000/001/010; loads with mode 011/110/111. Misaligned accesses are also illegal when trapping is enabled (see Configuration).
- REQ: drive `mem_req`=1 and `mem_we`=MemRw. On `mem_ack`:
  - Load: capture the extended result into `rdata`.
  - Both: → RESP.
- RESP: `done`=1 for one cycle, `busy`=0 at the cycle end, → IDLE.
- Store lanes (k = addr[1:0]):
  - B: `mem_be`=1<<k, `mem_wdata`={4{wdata[7:0]}}.
  - H: `mem_be`=addr[1]?1100:0011, `mem_wdata`={2{wdata[15:0]}}.
  - W: `mem_be`=1111, `mem_wdata`=wdata.
- Loads: `mem_be`=1111.
  - B/BU: select byte k; sign- or zero-extend.
  - H/HU: select half addr[1]; sign- or zero-extend.
  - W: full word.
- `start` while `busy`=1: ignored, no queueing.
- `mem_ack` outside REQ: ignored.
- `mem_rdata` is sampled only in the ack cycle.
- Reset value of every output: 0. `rdata` also resets to 0.
- Reset asserted mid-transaction:
  - Next edge forces IDLE and drops `mem_req`; no `done` is issued.
  - A late `mem_ack` afterwards is ignored.

## Timing
- All outputs are registered.
- Legal access, `start` at cycle 0, `mem_ack` returned at first request cycle:
  - Cycle 1: `mem_req` high.
  - Cycle 2: `done` high.
  - Cycle 3: next `start` accepted.
- Memory wait states add 1 cycle each; `mem_req`, `mem_addr`, `mem_be`, `mem_wdata` and `mem_we` stay stable until ack.
- Rejected access: `done`+`err` at cycle 1; `mem_req` never asserted.
- `busy` is high from cycle 1 through the `done` cycle inclusive.
- `busy` falls in the cycle after `done`.

## Configuration
- Macro: `LSU_MISALIGN_TRAP_EN`.
- Defined: misaligned accesses are illegal.
  - Misaligned = H/HU with addr[0]=1, or W with addr[1:0]≠00.
  - Result: `err`+`done` at cycle 1, no memory access.
- Undefined: the address is silently aligned and the access proceeds normally.
  - H forces addr[0]=0.
  - W forces addr[1:0]=00.
  - `err` is never raised for alignment.

## Structure
- Package `lsu_pkg`:
  - Mode constants LS_B=000, LS_H=001, LS_W=010, LS_BU=100, LS_HU=101.
  - FSM state encodings IDLE/REQ/RESP.
  - `be_for(mode, addr[1:0])` helper.
- Sub-module `lsu_load_align`: purely combinational; (mode, addr[1:0], mem_rdata) → extended 32-bit result. Instantiated once in `load_store_unit`.

## Test plan
- LB, addr=0x1003, mem_rdata=0x80FF_1234, 0-wait ack → mem_addr=0x1000, mem_be=1111, rdata=0xFFFF_FF80, done at cycle 2.
- LHU, addr=0x2002, mem_rdata=0xBEEF_0001, 3 wait states → rdata=0x0000_BEEF, done at cycle 5, mem_req steady cycles 1–4.
- SB, addr=0x3001, wdata=0x0000_00A5 → mem_we=1, mem_be=0010, mem_wdata=0xA5A5_A5A5.
- SW, addr=0x4002:
  - Macro defined: err+done at cycle 1, mem_req never high.
  - Macro undefined: mem_addr=0x4000, mem_be=1111, err=0.
- Load with mode 111 → err+done at cycle 1, no request. Second `start` during busy is ignored (exactly one done).
- `rst` asserted in REQ, then `mem_ack` one cycle later → all outputs 0 and no done pulse.
